// File: rtl/aes_gf_pkg.sv
// Shared definitions for the AES GF(2^8) constant multipliers.
// Select codes, the reduction constant and the xtime helper live here.
package aes_gf_pkg;

  localparam logic [2:0] MODE_X1   = 3'b000;
  localparam logic [2:0] MODE_X2   = 3'b001;
  localparam logic [2:0] MODE_X3   = 3'b010;
  localparam logic [2:0] MODE_X9   = 3'b011;
  localparam logic [2:0] MODE_XB   = 3'b100;
  localparam logic [2:0] MODE_XD   = 3'b101;
  localparam logic [2:0] MODE_XE   = 3'b110;
  localparam logic [2:0] MODE_ZERO = 3'b111;

  // Low byte of x^8+x^4+x^3+x+1; folded back in when bit 7 shifts out.
  localparam logic [7:0] AES_RED = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [7:0] red;
    if (a[7]) begin
      red = AES_RED;
    end else begin
      red = 8'h00;
    end
    return {a[6:0], 1'b0} ^ red;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Multiply-by-x in GF(2^8) modulo the AES polynomial; purely combinational.
module gf_xtime
  import aes_gf_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = xtime(din);

endmodule

// File: rtl/gf_mult.sv
// Registered GF(2^8) multiply by a selectable AES MixColumns/InvMixColumns
// coefficient; one byte lane, one-cycle latency, full throughput.
module gf_mult
  import aes_gf_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] multiplicand,
  input  logic [2:0] multiplier,
  output logic [7:0] product
);

  logic [7:0] x2_s;
  logic [7:0] x4_s;
  logic [7:0] x8_s;
  logic [7:0] prod_s;
  logic [7:0] product_r;

  // Doubling chain provides the power-of-two partial products.
  gf_xtime u_xtime2 (.din(multiplicand), .dout(x2_s));
  gf_xtime u_xtime4 (.din(x2_s),         .dout(x4_s));
  gf_xtime u_xtime8 (.din(x4_s),         .dout(x8_s));

  // Coefficient select: XOR of the partial products for the chosen constant.
  always_comb begin
    prod_s = 8'h00;
    case (multiplier)
      MODE_X1:   prod_s = multiplicand;
      MODE_X2:   prod_s = x2_s;
      MODE_X3:   prod_s = x2_s ^ multiplicand;
      MODE_X9:   prod_s = x8_s ^ multiplicand;
      MODE_XB:   prod_s = x8_s ^ x2_s ^ multiplicand;
      MODE_XD:   prod_s = x8_s ^ x4_s ^ multiplicand;
      MODE_XE:   prod_s = x8_s ^ x4_s ^ x2_s;
      MODE_ZERO: prod_s = 8'h00;
      default:   prod_s = 8'h00;
    endcase
  end

  // Product register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      product_r <= 8'h00;
    end else begin
      product_r <= prod_s;
    end
  end

  assign product = product_r;

endmodule

// File: tb/tb_gf_mult.sv
// Directed self-checking bench for gf_mult with hand-computed AES products.
`timescale 1ns/1ps
module tb_gf_mult;

  logic       clock;
  logic       reset_n;
  logic [7:0] multiplicand;
  logic [2:0] multiplier;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  gf_mult dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .product     (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int NB = 11;
  localparam logic [7:0] B2B_A [0:NB-1] =
    '{8'hD1, 8'hD1, 8'h80, 8'hFF, 8'hD1, 8'h00, 8'hD1, 8'hD1, 8'hD1, 8'hD1, 8'hD1};
  localparam logic [2:0] B2B_C [0:NB-1] =
    '{3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd6, 3'd4, 3'd7, 3'd5, 3'd6, 3'd2};
  localparam logic [7:0] B2B_E [0:NB-1] =
    '{8'hD1, 8'hB9, 8'h1B, 8'hE5, 8'h03, 8'h00, 8'hBA, 8'h00, 8'h6A, 8'h02, 8'h68};

  task automatic edge_sample();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_check(input logic [7:0] a, input logic [2:0] c,
                             input logic [7:0] exp, input string name);
    multiplicand = a;
    multiplier   = c;
    edge_sample();
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s a=%h code=%b got=%h expected=%h", name, a, c, product, exp);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    multiplicand = 8'hFF;
    multiplier   = 3'd2;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      checks++;
      if (product !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got=%h expected=00", i, product);
      end
    end
    reset_n = 1'b1;
    apply_check(8'h01, 3'd0, 8'h01, "reset_release");
  endtask

  task automatic test_forward();
    apply_check(8'hD1, 3'd0, 8'hD1, "fwd_x1");
    apply_check(8'hD1, 3'd1, 8'hB9, "fwd_x2");
    apply_check(8'hD1, 3'd2, 8'h68, "fwd_x3");
  endtask

  task automatic test_inverse();
    apply_check(8'hD1, 3'd3, 8'h03, "inv_x9");
    apply_check(8'hD1, 3'd4, 8'hBA, "inv_xb");
    apply_check(8'hD1, 3'd5, 8'h6A, "inv_xd");
    apply_check(8'hD1, 3'd6, 8'h02, "inv_xe");
    apply_check(8'hD1, 3'd7, 8'h00, "reserved_zero");
  endtask

  task automatic test_reduction();
    apply_check(8'h80, 3'd1, 8'h1B, "red_80_x2");
    apply_check(8'hFF, 3'd1, 8'hE5, "red_ff_x2");
    for (int c = 0; c < 8; c++) begin
      apply_check(8'h00, c[2:0], 8'h00, "zero_operand");
    end
  endtask

  task automatic test_back_to_back();
    // Prime with a value distinct from the first expected result.
    apply_check(8'h80, 3'd1, 8'h1B, "b2b_prime");
    for (int i = 0; i < NB; i++) begin
      apply_check(B2B_A[i], B2B_C[i], B2B_E[i], "b2b");
    end
  endtask

  task automatic test_midstream_reset();
    apply_check(8'hD1, 3'd1, 8'hB9, "mid_before");
    reset_n = 1'b0;
    apply_check(8'hFF, 3'd1, 8'h00, "mid_reset");
    reset_n = 1'b1;
    apply_check(8'h80, 3'd1, 8'h1B, "mid_after");
    apply_check(8'hD1, 3'd6, 8'h02, "mid_resume");
  endtask

  initial begin
    reset_n      = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 3'd0;
    test_reset();
    test_forward();
    test_inverse();
    test_reduction();
    test_back_to_back();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
